// File: rtl/dma_desc_scheduler.sv
// dma_desc_scheduler
//   Arbitrates DMA descriptors from one demand-miss source and NUM_PF
//   prefetch cores onto a single registered DMA descriptor slot. Demand has
//   priority. Prefetch cores share the remaining bandwidth round-robin, with
//   a starvation guard that forces one prefetch grant after STARVE_LIMIT
//   consecutive demand grants. An in-flight credit counter keeps
//   DEMAND_RESERVE slots for demand only. Completions are reported by
//   cpl_valid pulses.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   dem_valid/ready/desc   demand descriptor handshake
//   pf_valid/ready/desc    per-core prefetch handshake, core i at
//                          pf_desc[i*DESC_WIDTH +: DESC_WIDTH]
//   pf_enable              global prefetch throttle (0 = no prefetch grants)
//   out_valid/ready/desc   registered descriptor towards the DMA engine
//   out_src                0 = demand, i+1 = prefetch core i
//   cpl_valid              one pulse per completed transfer
//   inflight_cnt           outstanding descriptors, including the slot
//   err_underflow          sticky: completion seen with no outstanding work
module dma_desc_scheduler #(
  parameter int DESC_WIDTH     = 128,
  parameter int NUM_PF         = 4,
  parameter int MAX_INFLIGHT   = 8,
  parameter int DEMAND_RESERVE = 2,
  parameter int STARVE_LIMIT   = 15,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dem_valid,
  output logic                         dem_ready,
  input  logic [DESC_WIDTH-1:0]        dem_desc,
  input  logic [NUM_PF-1:0]            pf_valid,
  output logic [NUM_PF-1:0]            pf_ready,
  input  logic [NUM_PF*DESC_WIDTH-1:0] pf_desc,
  input  logic                         pf_enable,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DESC_WIDTH-1:0]        out_desc,
  output logic [3:0]                   out_src,
  input  logic                         cpl_valid,
  output logic [CNT_WIDTH-1:0]         inflight_cnt,
  output logic                         err_underflow
);

  localparam logic [CNT_WIDTH-1:0] MAX_C    = CNT_WIDTH'(MAX_INFLIGHT);
  localparam logic [CNT_WIDTH-1:0] PF_LIM_C = CNT_WIDTH'(MAX_INFLIGHT - DEMAND_RESERVE);
  localparam logic [7:0]           STARVE_C = 8'(STARVE_LIMIT);
  localparam logic [3:0]           NUM_PF_C = 4'(NUM_PF);

  logic                  out_valid_q, out_valid_d;
  logic [DESC_WIDTH-1:0] out_desc_q,  out_desc_d;
  logic [3:0]            out_src_q,   out_src_d;
  logic [CNT_WIDTH-1:0]  inflight_q,  inflight_d;
  logic                  err_q,       err_d;
  logic [3:0]            rr_ptr_q,    rr_ptr_d;
  logic [7:0]            starve_q,    starve_d;
  // Low while in reset and for the first edge after release, so no
  // handshake can complete before the state registers are out of reset.
  logic                  rdy_en_q,    rdy_en_d;

  logic                  slot_free_s, dem_elig_s, pf_elig_s, pf_req_s;
  logic                  force_pf_s, dem_grant_s, pf_grant_s, any_grant_s;
  logic [3:0]            pf_win_s;
  logic                  pf_found_s;
  logic [NUM_PF-1:0]     pf_ready_s;

  // Eligibility, starvation override and grant decision.
  always_comb begin
    slot_free_s = !out_valid_q || out_ready;
    dem_elig_s  = rdy_en_q && slot_free_s && (inflight_q < MAX_C);
    pf_elig_s   = rdy_en_q && slot_free_s && pf_enable && (inflight_q < PF_LIM_C);
    pf_req_s    = pf_elig_s && (|pf_valid);
    force_pf_s  = (starve_q == STARVE_C) && pf_req_s;
    dem_grant_s = dem_valid && dem_elig_s && !force_pf_s;
    pf_grant_s  = !dem_grant_s && pf_req_s;
    any_grant_s = dem_grant_s || pf_grant_s;
  end

  // Round-robin search: first valid core at or after rr_ptr, with wrap.
  always_comb begin
    int idx;
    idx        = 0;
    pf_win_s   = 4'd0;
    pf_found_s = 1'b0;
    for (int k = 0; k < NUM_PF; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_PF) begin
        idx = idx - NUM_PF;
      end else begin
        idx = idx;
      end
      if (!pf_found_s && pf_valid[idx]) begin
        pf_found_s = 1'b1;
        pf_win_s   = 4'(idx);
      end else begin
        pf_found_s = pf_found_s;
      end
    end
  end

  // One-hot prefetch ready for the winner, only when demand does not win.
  always_comb begin
    pf_ready_s = '0;
    for (int i = 0; i < NUM_PF; i++) begin
      pf_ready_s[i] = pf_grant_s && (pf_win_s == 4'(i));
    end
  end

  // Next state of the output slot, credits and arbitration state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_desc_d  = out_desc_q;
    out_src_d   = out_src_q;
    inflight_d  = inflight_q;
    err_d       = err_q;
    rr_ptr_d    = rr_ptr_q;
    starve_d    = starve_q;
    rdy_en_d    = 1'b1;

    if (dem_grant_s) begin
      out_valid_d = 1'b1;
      out_desc_d  = dem_desc;
      out_src_d   = 4'd0;
    end else if (pf_grant_s) begin
      out_valid_d = 1'b1;
      out_desc_d  = pf_desc[pf_win_s*DESC_WIDTH +: DESC_WIDTH];
      out_src_d   = pf_win_s + 4'd1;
    end else if (slot_free_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (pf_grant_s) begin
      rr_ptr_d = ((pf_win_s + 4'd1) == NUM_PF_C) ? 4'd0 : (pf_win_s + 4'd1);
      starve_d = 8'd0;
    end else if (dem_grant_s && pf_req_s && (starve_q != STARVE_C)) begin
      starve_d = starve_q + 8'd1;
    end else begin
      starve_d = starve_q;
    end

    // A grant and a completion in the same cycle cancel out.
    if (any_grant_s && cpl_valid) begin
      inflight_d = inflight_q;
    end else if (any_grant_s) begin
      inflight_d = inflight_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (cpl_valid) begin
      if (inflight_q != '0) begin
        inflight_d = inflight_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        err_d = 1'b1;
      end
    end else begin
      inflight_d = inflight_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_desc_q  <= '0;
      out_src_q   <= 4'd0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
      rr_ptr_q    <= 4'd0;
      starve_q    <= 8'd0;
      rdy_en_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_desc_q  <= out_desc_d;
      out_src_q   <= out_src_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
      rr_ptr_q    <= rr_ptr_d;
      starve_q    <= starve_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  assign dem_ready     = dem_elig_s && !force_pf_s;
  assign pf_ready      = pf_ready_s;
  assign out_valid     = out_valid_q;
  assign out_desc      = out_desc_q;
  assign out_src       = out_src_q;
  assign inflight_cnt  = inflight_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Directed testbench for dma_desc_scheduler (default parameters).
module tb_dma_desc_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dem_valid;
  logic         dem_ready;
  logic [127:0] dem_desc;
  logic [3:0]   pf_valid;
  logic [3:0]   pf_ready;
  logic [511:0] pf_desc;
  logic         pf_enable;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_desc;
  logic [3:0]   out_src;
  logic         cpl_valid;
  logic [7:0]   inflight_cnt;
  logic         err_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_desc_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dem_valid    (dem_valid),
    .dem_ready    (dem_ready),
    .dem_desc     (dem_desc),
    .pf_valid     (pf_valid),
    .pf_ready     (pf_ready),
    .pf_desc      (pf_desc),
    .pf_enable    (pf_enable),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_desc     (out_desc),
    .out_src      (out_src),
    .cpl_valid    (cpl_valid),
    .inflight_cnt (inflight_cnt),
    .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] src_rr [5];
    logic [3:0] rdy_rr [5];
    logic [3:0] src_cr [6];
    src_rr = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    rdy_rr = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    src_cr = '{4'd4, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1};

    rst_n = 1'b0; dem_valid = 1'b0; dem_desc = 128'h0; pf_valid = 4'b0000;
    pf_desc = {128'h103, 128'h102, 128'h101, 128'h100};
    pf_enable = 1'b1; out_ready = 1'b1; cpl_valid = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_desc", out_desc, 128'd0);
    chk("rst_out_src", 128'(out_src), 128'd0);
    chk("rst_dem_ready", 128'(dem_ready), 128'd0);
    chk("rst_pf_ready", 128'(pf_ready), 128'd0);
    chk("rst_inflight", 128'(inflight_cnt), 128'd0);
    chk("rst_err", 128'(err_underflow), 128'd0);
    rst_n = 1'b1;
    tick();

    // Single demand descriptor
    dem_valid = 1'b1; dem_desc = 128'hA5;
    #1;
    chk("dem_ready_same_cycle", 128'(dem_ready), 128'd1);
    tick();
    dem_valid = 1'b0;
    chk("dem_out_valid", 128'(out_valid), 128'd1);
    chk("dem_out_desc", out_desc, 128'hA5);
    chk("dem_out_src", 128'(out_src), 128'd0);
    chk("dem_inflight", 128'(inflight_cnt), 128'd1);
    cpl_valid = 1'b1;
    tick();
    cpl_valid = 1'b0;
    chk("dem_cpl_inflight", 128'(inflight_cnt), 128'd0);
    chk("dem_slot_clear", 128'(out_valid), 128'd0);

    // Round robin over four prefetch cores
    pf_valid = 4'b1111;
    #1;
    chk("rr_first_ready", 128'(pf_ready), 128'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_src", 128'(out_src), 128'(src_rr[i]));
      chk("rr_ready", 128'(pf_ready), 128'(rdy_rr[i]));
    end
    chk("rr_desc_wrap", out_desc, 128'h100);
    pf_valid = 4'b0000;
    cpl_valid = 1'b1;
    repeat (5) tick();
    cpl_valid = 1'b0;
    chk("rr_drain", 128'(inflight_cnt), 128'd0);

    // Starvation guard: 15 demand grants, one forced prefetch, demand again
    dem_valid = 1'b1; dem_desc = 128'hD0; pf_valid = 4'b0100;
    #1;
    chk("st_dem_first", 128'(dem_ready), 128'd1);
    chk("st_pf_blocked", 128'(pf_ready), 128'd0);
    tick();
    cpl_valid = 1'b1;
    chk("st_grant_src", 128'(out_src), 128'd0);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("st_grant_src", 128'(out_src), 128'd0);
    end
    chk("st_force_dem_ready", 128'(dem_ready), 128'd0);
    chk("st_force_pf_ready", 128'(pf_ready), 128'b0100);
    tick();
    chk("st_forced_src", 128'(out_src), 128'd3);
    chk("st_forced_desc", out_desc, 128'h102);
    chk("st_inflight", 128'(inflight_cnt), 128'd1);
    chk("st_cleared_dem_ready", 128'(dem_ready), 128'd1);
    chk("st_cleared_pf_ready", 128'(pf_ready), 128'd0);
    tick();
    chk("st_demand_again", 128'(out_src), 128'd0);
    dem_valid = 1'b0; pf_valid = 4'b0000;
    tick();
    cpl_valid = 1'b0;
    chk("st_drain", 128'(inflight_cnt), 128'd0);

    // Credit limits and demand reserve
    pf_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("cr_pf_src", 128'(out_src), 128'(src_cr[i]));
      chk("cr_pf_inflight", 128'(inflight_cnt), 128'(i + 1));
    end
    chk("cr_pf_blocked", 128'(pf_ready), 128'd0);
    chk("cr_dem_open", 128'(dem_ready), 128'd1);
    dem_valid = 1'b1; dem_desc = 128'hE0;
    tick();
    chk("cr_dem7", 128'(inflight_cnt), 128'd7);
    tick();
    chk("cr_dem8", 128'(inflight_cnt), 128'd8);
    chk("cr_full_dem_ready", 128'(dem_ready), 128'd0);
    chk("cr_full_pf_ready", 128'(pf_ready), 128'd0);
    tick();
    chk("cr_full_hold", 128'(inflight_cnt), 128'd8);
    chk("cr_full_slot_clear", 128'(out_valid), 128'd0);
    cpl_valid = 1'b1;
    tick();
    cpl_valid = 1'b0;
    #1;
    chk("cr_cpl_inflight", 128'(inflight_cnt), 128'd7);
    chk("cr_cpl_dem_ready", 128'(dem_ready), 128'd1);
    chk("cr_cpl_pf_ready", 128'(pf_ready), 128'd0);
    tick();
    chk("cr_regrant", 128'(inflight_cnt), 128'd8);
    chk("cr_regrant_desc", out_desc, 128'hE0);
    dem_valid = 1'b0; pf_valid = 4'b0000;
    cpl_valid = 1'b1;
    repeat (8) tick();
    cpl_valid = 1'b0;
    chk("cr_drain", 128'(inflight_cnt), 128'd0);

    // Back-pressure: out_ready low for 5 cycles
    dem_valid = 1'b1; dem_desc = 128'hB1; pf_valid = 4'b0001;
    tick();
    out_ready = 1'b0; dem_desc = 128'hB2;
    #1;
    chk("bp_dem_ready", 128'(dem_ready), 128'd0);
    chk("bp_pf_ready", 128'(pf_ready), 128'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_desc", out_desc, 128'hB1);
      chk("bp_src", 128'(out_src), 128'd0);
      chk("bp_dem_ready", 128'(dem_ready), 128'd0);
      chk("bp_pf_ready", 128'(pf_ready), 128'd0);
      chk("bp_inflight", 128'(inflight_cnt), 128'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_dem_ready", 128'(dem_ready), 128'd1);
    tick();
    chk("bp_release_desc", out_desc, 128'hB2);
    chk("bp_release_inflight", 128'(inflight_cnt), 128'd2);
    dem_valid = 1'b0;
    #1;
    chk("bp_pf_wrap_ready", 128'(pf_ready), 128'b0001);
    tick();
    chk("bp_pf_src", 128'(out_src), 128'd1);
    chk("bp_pf_desc", out_desc, 128'h100);
    chk("bp_pf_inflight", 128'(inflight_cnt), 128'd3);
    pf_valid = 4'b0000;
    tick();
    cpl_valid = 1'b1;
    repeat (3) tick();
    cpl_valid = 1'b0;
    chk("bp_drain", 128'(inflight_cnt), 128'd0);
    chk("uf_err_before", 128'(err_underflow), 128'd0);

    // Underflow: completion with nothing outstanding
    cpl_valid = 1'b1;
    tick();
    cpl_valid = 1'b0;
    chk("uf_err_set", 128'(err_underflow), 128'd1);
    chk("uf_inflight", 128'(inflight_cnt), 128'd0);
    tick(); tick();
    chk("uf_err_sticky", 128'(err_underflow), 128'd1);

    // Prefetch throttle: no prefetch grants, demand unaffected
    pf_enable = 1'b0; pf_valid = 4'b1111;
    #1;
    chk("thr_pf_ready", 128'(pf_ready), 128'd0);
    chk("thr_dem_ready", 128'(dem_ready), 128'd1);
    tick();
    chk("thr_no_grant", 128'(out_valid), 128'd0);
    dem_valid = 1'b1; dem_desc = 128'hC3;
    tick();
    chk("thr_dem_desc", out_desc, 128'hC3);
    chk("thr_dem_src", 128'(out_src), 128'd0);
    chk("thr_inflight", 128'(inflight_cnt), 128'd1);
    dem_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_desc_scheduler.md
# dma_desc_scheduler

Arbitrates DMA descriptors from one demand-miss source and NUM_PF speculative prefetch cores onto the single DMA engine descriptor port. Demand traffic has priority. Prefetch requesters share the remaining bandwidth round-robin, with a starvation guard and an in-flight credit limit that reserves DMA slots for demand misses. The block sits between the prefetch cores/miss handler and the DMA engine, and tracks outstanding transfers via completion pulses.

## Interface
- DESC_WIDTH, 128, descriptor width (passed through unmodified)
- NUM_PF, 4, number of prefetch requesters (1..15)
- MAX_INFLIGHT, 8, max outstanding descriptors (granted, not yet completed)
- DEMAND_RESERVE, 2, slots usable only by demand (< MAX_INFLIGHT)
- STARVE_LIMIT, 15, consecutive demand grants before a prefetch grant is forced
- CNT_WIDTH, 8, width of inflight_cnt

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- dem_valid / dem_ready  in / out  1 / 1  demand descriptor handshake
- dem_desc  in  DESC_WIDTH  demand descriptor
- pf_valid / pf_ready  in / out  NUM_PF / NUM_PF  per-core prefetch handshake
- pf_desc  in  NUM_PF*DESC_WIDTH  core i at [i*DESC_WIDTH +: DESC_WIDTH]
- pf_enable  in  1  global prefetch throttle; 0 = no prefetch grants
- out_valid / out_ready  out / in  1 / 1  descriptor to DMA engine
- out_desc  out  DESC_WIDTH  registered granted descriptor
- out_src  out  4  source of out_desc: 0 = demand, i+1 = prefetch core i
- cpl_valid  in  1  one pulse per completed DMA transfer
- inflight_cnt  out  CNT_WIDTH  outstanding descriptor count
- err_underflow  out  1  sticky: cpl_valid seen with inflight_cnt == 0

## Operation
- Output slot: one register (out_valid, out_desc, out_src). slot_free = !out_valid || out_ready.
- Eligibility:
  - dem_elig = slot_free && inflight_cnt < MAX_INFLIGHT.
  - pf_elig = slot_free && pf_enable && inflight_cnt < MAX_INFLIGHT - DEMAND_RESERVE.
- Grant decision each cycle, with pf_req = pf_elig && |pf_valid:
  - force_pf = (starve_cnt == STARVE_LIMIT) && pf_req.
  - Demand wins if dem_valid && dem_elig && !force_pf. Otherwise a prefetch core wins if pf_req.
  - Prefetch winner: first valid index starting at rr_ptr, ascending, with wrap.
- dem_ready = dem_elig && !force_pf. It does not depend on dem_valid.
- pf_ready[i] = 1 only for the prefetch winner, and only when demand does not win. It may depend on pf_valid.
- On grant: load the winner's descriptor and source into the slot, set out_valid, inflight_cnt += 1.
- If slot_free and there is no grant, out_valid clears once out_ready has been seen.
- rr_ptr: after a prefetch grant to core i, rr_ptr = (i+1) mod NUM_PF. It is unchanged otherwise.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on a demand grant while pf_req is true.
  - Cleared on any prefetch grant.
  - Unchanged otherwise.
- inflight_cnt:
  - Grant and cpl_valid in the same cycle: unchanged.
  - cpl_valid alone with count > 0: -1.
  - cpl_valid with count == 0: count stays 0 and err_underflow sets.
- err_underflow is cleared only by reset.
- pf_enable = 0 with prefetch descriptors pending: no pf_ready, and requesters hold their data. Demand continues unaffected.

## Timing
- Reset (async assert, synchronous release), all of the following are 0:
  - out_valid, out_desc, out_src, dem_ready, pf_ready, inflight_cnt, err_underflow, rr_ptr, starve_cnt.
- Latency: a descriptor accepted in cycle N is presented on out_desc in cycle N+1.
- Throughput: 1 descriptor/cycle while out_ready = 1 and credits are available.
- out_valid high with out_ready low: out_desc/out_src are held stable and no input is accepted.
- Credits: inflight_cnt includes the descriptor in the slot. At MAX_INFLIGHT, all readies are 0 until a cpl_valid is seen. A cpl_valid in cycle N can enable a grant in cycle N+1 (count is registered).
- Reset mid-operation: the slot content is dropped, and outstanding count and arbitration state are lost.

## Test plan
- Reset, then a single dem_valid with desc 0xA5: dem_ready=1 in the same cycle; out_valid=1, out_desc=0xA5, out_src=0 next cycle; inflight_cnt=1.
- pf_valid=4'b1111 continuous, out_ready=1, no completions lost: grant order is cores 0,1,2,3,0 (out_src 1,2,3,4,1).
- Demand and pf_valid[2] both held continuously: 15 demand grants, then one grant with out_src=3, then demand again; starve_cnt returns to 0.
- No completions: 6 prefetch grants succeed, then pf_ready=0; demand still gets 2 more (inflight_cnt=8), then dem_ready=0; one cpl_valid drops inflight_cnt to 7 and re-enables demand only.
- out_ready=0 for 5 cycles with requesters pending: out_desc is stable, all readies are 0, and nothing is dropped on release.
- cpl_valid with inflight_cnt=0: err_underflow=1 and stays set; inflight_cnt stays 0.
